// File: rtl/dircc_types_pkg.sv
// DiRCC packet types shared by the Avalon-ST packet receiver and its consumers.
package dircc_types_pkg;

    typedef enum logic {
        FALSE = 1'b0,
        TRUE  = 1'b1
    } bool;

    typedef struct packed {
        logic [31:0] hw_addr;
        logic [15:0] sw_addr;
        logic [3:0]  port;
        logic [3:0]  flag;
    } address_t;

    typedef struct packed {
        address_t    dest_addr;
        address_t    src_addr;
        logic [31:0] lamport;
        logic [95:0] data;
    } packet_t;

    localparam int PACKET_WORDS = 8;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_RECV = 2'd1,
        RX_DONE = 2'd2
    } rx_state_e;

endpackage

// File: rtl/dircc_avalon_st_packet_receiver.sv
// Avalon-ST sink assembling one 8-word DiRCC packet and holding it until acknowledged.
// Optional DIRCC_RX_ERROR_STATS_EN adds rx_error / rx_error_count framing-error outputs.
module dircc_avalon_st_packet_receiver
    import dircc_types_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int EMPTY_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef DIRCC_RX_ERROR_STATS_EN
    output logic                    rx_error,
    output logic [7:0]              rx_error_count,
`endif
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_startofpacket,
    input  logic                    in_endofpacket,
    input  logic [EMPTY_WIDTH-1:0]  in_empty,
    output logic [239:0]            packet_data,
    output logic                    receive_done,
    output logic                    receive_nearly_done,
    input  logic                    receive_ack
);

    localparam logic [2:0] LAST_IDX = 3'(PACKET_WORDS - 1);

    rx_state_e   state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    packet_t     packet_q, packet_d;
    logic        beat;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic        err_d;
    logic [31:0] word;

    assign word = in_data[31:0];
    assign beat = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RX_IDLE;
            idx_q    <= 3'd0;
            packet_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            packet_q <= packet_d;
        end
    end

    // SOP takes priority over everything so a restarted packet always re-anchors at word 0.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        wr_idx  = idx_q;
        err_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (beat) begin
                    if (in_startofpacket) begin
                        wr_en   = 1'b1;
                        wr_idx  = 3'd0;
                        idx_d   = 3'd1;
                        state_d = RX_RECV;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RX_RECV: begin
                if (beat) begin
                    if (in_startofpacket) begin
                        wr_en  = 1'b1;
                        wr_idx = 3'd0;
                        idx_d  = 3'd1;
                        err_d  = 1'b1;
                    end else if (idx_q == LAST_IDX) begin
                        wr_en   = 1'b1;
                        idx_d   = 3'd0;
                        state_d = RX_DONE;
                    end else if (in_endofpacket) begin
                        idx_d   = 3'd0;
                        err_d   = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        wr_en = 1'b1;
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            RX_DONE: begin
                if (receive_ack) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_comb begin
        packet_d = packet_q;
        if (wr_en) begin
            case (wr_idx)
                3'd0: packet_d.dest_addr.hw_addr = word;
                3'd1: begin
                    packet_d.dest_addr.sw_addr = word[31:16];
                    packet_d.dest_addr.port    = word[15:12];
                    packet_d.dest_addr.flag    = word[11:8];
                end
                3'd2: packet_d.src_addr.hw_addr = word;
                3'd3: begin
                    packet_d.src_addr.sw_addr = word[31:16];
                    packet_d.src_addr.port    = word[15:12];
                    packet_d.src_addr.flag    = word[11:8];
                end
                3'd4: packet_d.lamport       = word;
                3'd5: packet_d.data[31:0]    = word;
                3'd6: packet_d.data[63:32]   = word;
                default: packet_d.data[95:64] = word;
            endcase
        end
    end

    always_comb begin
        in_ready            = ~reset & (state_q != RX_DONE);
        receive_done        = (state_q == RX_DONE);
        receive_nearly_done = (state_q == RX_RECV) && (idx_q == LAST_IDX);
        packet_data         = packet_q;
    end

`ifdef DIRCC_RX_ERROR_STATS_EN
    logic       rx_error_q;
    logic [7:0] rx_error_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_error_q       <= 1'b0;
            rx_error_count_q <= 8'd0;
        end else begin
            rx_error_q <= err_d;
            if (err_d && (rx_error_count_q != 8'hFF)) begin
                rx_error_count_q <= rx_error_count_q + 8'd1;
            end
        end
    end

    assign rx_error       = rx_error_q;
    assign rx_error_count = rx_error_count_q;
`else
    logic unused_err;
    assign unused_err = err_d;
`endif

    logic unused_empty;
    assign unused_empty = ^in_empty;

endmodule

// File: tb/tb_dircc_avalon_st_packet_receiver.sv
// Randomized self-checking bench for the DiRCC Avalon-ST packet receiver against a word-queue model.
module tb_dircc_avalon_st_packet_receiver;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_sop;
    logic         in_eop;
    logic [1:0]   in_empty;
    logic [239:0] packet_data;
    logic         receive_done;
    logic         receive_nearly_done;
    logic         receive_ack;
`ifdef DIRCC_RX_ERROR_STATS_EN
    logic         rx_error;
    logic [7:0]   rx_error_count;
`endif

    always #5 clk = ~clk;

    dircc_avalon_st_packet_receiver dut (
        .clk                 (clk),
        .reset               (reset),
`ifdef DIRCC_RX_ERROR_STATS_EN
        .rx_error            (rx_error),
        .rx_error_count      (rx_error_count),
`endif
        .in_data             (in_data),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_startofpacket    (in_sop),
        .in_endofpacket      (in_eop),
        .in_empty            (in_empty),
        .packet_data         (packet_data),
        .receive_done        (receive_done),
        .receive_nearly_done (receive_nearly_done),
        .receive_ack         (receive_ack)
    );

    int errors = 0;
    int checks = 0;

    // Model: words of the packet under assembly, plus the held packet.
    logic [31:0]  m_cur[$];
    logic         m_done;
    logic [239:0] m_pkt;
    logic         m_err;
    int           m_err_cnt;

    task automatic check_eq(input string tag, input logic [239:0] got, input logic [239:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cur.delete();
        m_done    = 1'b0;
        m_pkt     = '0;
        m_err     = 1'b0;
        m_err_cnt = 0;
    endtask

    task automatic model_step(input bit v, input logic [31:0] d, input bit sop, input bit eop, input bit ack);
        m_err = 1'b0;
        if (m_done) begin
            if (ack) m_done = 1'b0;
        end else if (v) begin
            if (sop) begin
                if (m_cur.size() != 0) m_err = 1'b1;
                m_cur.delete();
                m_cur.push_back(d);
            end else if (m_cur.size() == 0) begin
                m_err = 1'b1;
            end else begin
                m_cur.push_back(d);
                if (m_cur.size() == 8) begin
                    m_pkt = {m_cur[0], m_cur[1][31:8], m_cur[2], m_cur[3][31:8],
                             m_cur[4], m_cur[7], m_cur[6], m_cur[5]};
                    m_done = 1'b1;
                    m_cur.delete();
                end else if (eop) begin
                    m_err = 1'b1;
                    m_cur.delete();
                end
            end
        end
        if (m_err && m_err_cnt < 255) m_err_cnt++;
    endtask

    task automatic compare_outputs();
        check_eq("in_ready", in_ready, !m_done && !reset);
        check_eq("done", receive_done, m_done);
        check_eq("nearly_done", receive_nearly_done, m_cur.size() == 7);
        if (m_done) check_eq("packet_data", packet_data, m_pkt);
`ifdef DIRCC_RX_ERROR_STATS_EN
        check_eq("rx_error", rx_error, m_err);
        check_eq("rx_error_count", rx_error_count, m_err_cnt[7:0]);
`endif
    endtask

    task automatic cycle(input bit v, input logic [31:0] d, input bit sop, input bit eop,
                         input bit ack, output bit accepted);
        @(negedge clk);
        in_valid    = v;
        in_data     = d;
        in_sop      = sop;
        in_eop      = eop;
        receive_ack = ack;
        in_empty    = 2'($urandom);
        compare_outputs();
        accepted = v && !m_done;
        @(posedge clk);
        model_step(v, d, sop, eop, ack);
    endtask

    task automatic idle(input int n, input bit ack);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, ack, acc);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset       = 1'b1;
        in_valid    = 1'b0;
        receive_ack = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            compare_outputs();
        end
        check_eq("rst_packet", packet_data, 240'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic rand_words(output logic [31:0] w[8], input logic [31:0] lamport);
        for (int i = 0; i < 8; i++) w[i] = $urandom;
        w[4] = lamport;
    endtask

    // Sends beats first..last of w with handshake; eop_at marks the EOP beat, sop_at the SOP beat.
    task automatic send_words(input logic [31:0] w[8], input int first, input int last,
                              input int sop_at, input int eop_at);
        bit acc;
        for (int i = first; i <= last; i++) begin
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++)
                cycle(1'b1, w[i], i == sop_at, i == eop_at, 1'b0, acc);
            check_eq("beat_accept", acc, 1'b1);
        end
    endtask

    logic [31:0] wa[8];
    logic [31:0] wb[8];
    bit          acc;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
        in_empty = '0; receive_ack = 1'b0;
        model_reset();

        do_reset(10);
        idle(10, 1'b0);
        check_eq("post_rst_ready", in_ready, 1'b1);

        rand_words(wa, 32'd0);
        send_words(wa, 0, 7, 0, 7);
        idle(1, 1'b0);
        check_eq("full_done", receive_done, 1'b1);
        check_eq("full_dest_hw", packet_data[239:208], wa[0]);
        idle(1, 1'b1);
        idle(2, 1'b0);

        rand_words(wa, $urandom);
        send_words(wa, 0, 6, 0, 99);
        idle(1, 1'b0);
        check_eq("partial_nearly", receive_nearly_done, 1'b1);
        check_eq("partial_ready", in_ready, 1'b1);

        rand_words(wa, 32'd0);
        rand_words(wb, 32'd1);
        send_words(wa, 0, 7, 0, 7);
        for (int i = 0; i < 5; i++) cycle(1'b1, wb[0], 1'b1, 1'b0, 1'b0, acc);
        check_eq("hold_ready", in_ready, 1'b0);
        check_eq("hold_lamport", packet_data[127:96], 32'd0);
        cycle(1'b1, wb[0], 1'b1, 1'b0, 1'b1, acc);
        send_words(wb, 0, 7, 0, 7);
        idle(1, 1'b0);
        check_eq("hold_b_lamport", packet_data[127:96], 32'd1);
        idle(1, 1'b1);

        send_words(wa, 0, 2, 0, 99);
        do_reset(3);
        idle(2, 1'b0);
        check_eq("midrst_nearly", receive_nearly_done, 1'b0);

        rand_words(wa, $urandom);
        send_words(wa, 0, 4, 0, 4);
        idle(1, 1'b0);
        check_eq("early_eop_done", receive_done, 1'b0);
        send_words(wa, 0, 2, 0, 99);
        send_words(wa, 0, 7, 0, 7);
        idle(1, 1'b0);
        check_eq("restart_done", receive_done, 1'b1);
`ifdef DIRCC_RX_ERROR_STATS_EN
        check_eq("err_count_two", rx_error_count, 8'd2);
`endif
        idle(1, 1'b1);

        for (int c = 0; c < 4000; c++) begin
            int n;
            bit v, sop, eop, ack;
            n   = m_cur.size();
            v   = ($urandom_range(0, 9) < 7);
            sop = 1'b0;
            eop = 1'b0;
            if (n == 0) sop = ($urandom_range(0, 9) < 8);
            else if (n < 7) begin
                sop = ($urandom_range(0, 39) == 0);
                eop = !sop && ($urandom_range(0, 39) == 0);
            end else eop = ($urandom_range(0, 9) < 9);
            ack = ($urandom_range(0, 3) == 0);
            cycle(v, $urandom, sop, eop, ack, acc);
        end
        idle(1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
